// File: rtl/dc_bu_pkg.sv
// Shared types and helpers for the buffering-unit line controller.
package dc_bu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } dc_bu_rd_state_t;

    // Column counters must hold BANK_SIZE itself (a full line length).
    function automatic int dc_bu_col_width(input int bank_size);
        return $clog2(bank_size) + 32'sd1;
    endfunction

endpackage

// File: rtl/dc_bu_skid_fifo.sv
// Two-entry data+eol FIFO that sits between the memory read port and the scaler.
module dc_bu_skid_fifo #(
    parameter int WORD_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  push_eol,
    input  logic                  pop,
    output logic [WORD_WIDTH-1:0] pop_data,
    output logic                  pop_eol,
    output logic                  full,
    output logic                  empty
);
    logic [WORD_WIDTH-1:0] data_r [2];
    logic [1:0]            eol_r;
    logic                  wptr_r;
    logic                  rptr_r;
    logic [1:0]            cnt_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign empty     = (cnt_r == 2'd0);
    assign full      = (cnt_r == 2'd2);
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign pop_data  = data_r[rptr_r];
    assign pop_eol   = eol_r[rptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r[0] <= {WORD_WIDTH{1'b0}};
            data_r[1] <= {WORD_WIDTH{1'b0}};
            eol_r     <= 2'b00;
            wptr_r    <= 1'b0;
            rptr_r    <= 1'b0;
            cnt_r     <= 2'd0;
        end else begin
            if (push_ok_s) begin
                data_r[wptr_r] <= push_data;
                eol_r[wptr_r]  <= push_eol;
                wptr_r         <= ~wptr_r;
            end
            if (pop_ok_s) begin
                rptr_r <= ~rptr_r;
            end
            cnt_r <= cnt_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

endmodule

// File: rtl/dc_bu_line_ctrl.sv
// Ping-pong line buffer controller: writes incoming lines into one memory bank
// while replaying the previously completed line from the other bank.
module dc_bu_line_ctrl
    import dc_bu_pkg::*;
#(
    parameter int BUFF_ADDR_WIDTH = 10,
    parameter int MEMORY_HEIGHT   = 128,
    parameter int WORD_WIDTH      = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_WIDTH-1:0]      in_data,
    input  logic                       in_eol,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_WIDTH-1:0]      out_data,
    output logic                       out_eol,
    output logic                       err_long,
    output logic                       mem_ce,
    output logic                       mem_we,
    output logic [BUFF_ADDR_WIDTH-1:0] mem_waddr,
    output logic [WORD_WIDTH-1:0]      mem_wdata,
    output logic                       mem_re,
    output logic [BUFF_ADDR_WIDTH-1:0] mem_raddr,
    input  logic [WORD_WIDTH-1:0]      mem_rdata
);
    localparam int                         BANK_SIZE  = MEMORY_HEIGHT / 2;
    localparam int                         COL_W      = dc_bu_col_width(BANK_SIZE);
    localparam logic [COL_W-1:0]           COL_ONE    = COL_W'(32'd1);
    localparam logic [COL_W-1:0]           COL_LAST   = COL_W'(BANK_SIZE - 1);
    localparam logic [BUFF_ADDR_WIDTH-1:0] BANK1_BASE = BUFF_ADDR_WIDTH'(BANK_SIZE);
    localparam logic [BUFF_ADDR_WIDTH-1:0] BANK0_BASE = {BUFF_ADDR_WIDTH{1'b0}};

    logic                       wbank_r;
    logic                       rbank_r;
    logic [COL_W-1:0]           wcol_r;
    logic [COL_W-1:0]           rcol_r;
    logic [1:0]                 full_r;
    logic [1:0]                 full_set_s;
    logic [1:0]                 full_clr_s;
    logic [COL_W-1:0]           len_r [2];
    dc_bu_rd_state_t            state_r;
    dc_bu_rd_state_t            state_nxt_s;

    logic                       accept_s;
    logic                       wlast_col_s;
    logic                       wclose_s;
    logic [BUFF_ADDR_WIDTH-1:0] waddr_s;
    logic                       mem_we_r;
    logic [BUFF_ADDR_WIDTH-1:0] mem_waddr_r;
    logic [WORD_WIDTH-1:0]      mem_wdata_r;
    logic                       err_long_r;

    logic                       rd_req_s;
    logic                       mem_re_s;
    logic                       rd_last_s;
    logic                       rd_eff_r;
    logic                       rd_eol_r;
    logic [1:0]                 fifo_occ_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic                       pop_s;

    // Write side
    assign in_ready    = ~full_r[wbank_r];
    assign accept_s    = in_valid & in_ready;
    assign wlast_col_s = (wcol_r == COL_LAST);
    assign wclose_s    = accept_s & (in_eol | wlast_col_s);
    assign waddr_s     = (wbank_r ? BANK1_BASE : BANK0_BASE) + BUFF_ADDR_WIDTH'(wcol_r);

    // Read side; a pop this cycle frees a slot so reads can stream at one per cycle
    assign pop_s      = out_valid & out_ready;
    assign fifo_occ_s = fifo_full_s ? 2'd2 : (fifo_empty_s ? 2'd0 : 2'd1);
    assign rd_req_s   = (state_r == READ) &
                        ((fifo_occ_s + {1'b0, rd_eff_r} - {1'b0, pop_s}) < 2'd2);
    assign mem_re_s   = rd_req_s & ~mem_we_r;
    assign rd_last_s  = mem_re_s & (rcol_r == (len_r[rbank_r] - COL_ONE));

    // Set and clear always hit different banks, so both apply together
    assign full_set_s = wclose_s  ? (wbank_r ? 2'b10 : 2'b01) : 2'b00;
    assign full_clr_s = rd_last_s ? (rbank_r ? 2'b10 : 2'b01) : 2'b00;

    assign mem_we    = mem_we_r;
    assign mem_waddr = mem_waddr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_re    = mem_re_s;
    assign mem_raddr = (rbank_r ? BANK1_BASE : BANK0_BASE) + BUFF_ADDR_WIDTH'(rcol_r);
    assign mem_ce    = mem_we_r | mem_re_s;
    assign err_long  = err_long_r;
    assign out_valid = ~fifo_empty_s;

    // Write side: register the memory write and track the open line.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_r     <= 1'b0;
            wcol_r      <= {COL_W{1'b0}};
            len_r[0]    <= {COL_W{1'b0}};
            len_r[1]    <= {COL_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_waddr_r <= {BUFF_ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {WORD_WIDTH{1'b0}};
            err_long_r  <= 1'b0;
        end else begin
            mem_we_r   <= accept_s;
            err_long_r <= accept_s & wlast_col_s & ~in_eol;
            if (accept_s) begin
                mem_waddr_r <= waddr_s;
                mem_wdata_r <= in_data;
            end
            if (wclose_s) begin
                len_r[wbank_r] <= wcol_r + COL_ONE;
                wbank_r        <= ~wbank_r;
                wcol_r         <= {COL_W{1'b0}};
            end else if (accept_s) begin
                wcol_r <= wcol_r + COL_ONE;
            end
        end
    end

    // Bank-full flags shared between the write and read sides.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r | full_set_s) & ~full_clr_s;
        end
    end

    // Read side: FSM state, read column, and the in-flight read tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rbank_r  <= 1'b0;
            rcol_r   <= {COL_W{1'b0}};
            rd_eff_r <= 1'b0;
            rd_eol_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            rd_eff_r <= mem_re_s;
            rd_eol_r <= rd_last_s;
            if (rd_last_s) begin
                rbank_r <= ~rbank_r;
                rcol_r  <= {COL_W{1'b0}};
            end else if (mem_re_s) begin
                rcol_r <= rcol_r + COL_ONE;
            end
        end
    end

    // Read FSM next state: start on a full bank, return to IDLE after its last read.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (full_r[rbank_r]) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ: begin
                if (rd_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = READ;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    dc_bu_skid_fifo #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_eff_r),
        .push_data(mem_rdata),
        .push_eol (rd_eol_r),
        .pop      (pop_s),
        .pop_data (out_data),
        .pop_eol  (out_eol),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

endmodule
